booth_r4_mult: RTL
==================

# booth_r4_mult

Parametrised iterative radix-4 (modified Booth) multiplier. Successor to the fixed 16-bit high-radix multiplier. Adds a configurable operand width, a start/done handshake and a per-operation signed/unsigned mode. Sits on the datapath as a multi-cycle arithmetic unit, retiring two multiplier bits per clock.

## Interface
- `WIDTH`, default 16: operand width. Must be even and ≥4; product is 2*WIDTH bits.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned; latched with operands
- `x`  in  WIDTH  multiplicand; latched on accepted start
- `y`  in  WIDTH  multiplier; latched on accepted start
- `busy`  out  1  high while in RUN
- `done`  out  1  single-cycle pulse; `out` valid from this cycle on
- `out`  out  2*WIDTH  product; held until the next accepted start

## Operation
- States:
  - IDLE: reset state.
  - RUN: iterating.
  - DONE: one cycle, then IDLE.
- Accepted start (IDLE or DONE, `start`=1):
  - Latch x, y and mode.
  - Clear the accumulator.
  - Load iteration counter with N = WIDTH/2+1.
  - Go to RUN.
- Operand extension: x and y are extended to WIDTH+2 bits. Sign-extend when `signed_mode`=1, zero-extend otherwise. This gives N Booth digits, which covers the full unsigned range.
- RUN, each cycle:
  - Recode bits {y[2i+1], y[2i], y[2i-1]} (y[-1]=0) into a digit in {-2,-1,0,+1,+2}.
  - Add digit·X to the upper part of the accumulator.
  - Arithmetic-shift the accumulator and the multiplier register right by 2.
  - Decrement the counter.
- When the counter reaches 0: go to DONE, register `out` = low 2*WIDTH bits of the accumulator, assert `done`.
- DONE: with `start`=1 go straight back to RUN (back-to-back operation); otherwise go to IDLE.
- `start` in RUN: ignored. Operands are not re-latched and the running operation is unaffected.
- Internal width: accumulator is 2*WIDTH+4 bits. Partial products are WIDTH+3-bit signed values, so nothing overflows internally. The result is exact modulo 2^(2*WIDTH), and exact in both modes.
- `x`/`y` changing during RUN: no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `out`=0, state IDLE.
- Reset during RUN: aborts. Next cycle is IDLE, `out`=0, and no `done` pulse is produced.
- Reset wins over a simultaneous `start`.
- Latency (full): start sampled at edge k → RUN for N cycles → `done`=1 in the cycle after edge k+N. For WIDTH=16 that is N=9, so `done` is seen 10 cycles after start.
- `busy`:
  - Rises the cycle after an accepted start.
  - Falls in the same cycle `done` rises.
- Throughput: one result every N+1 cycles with back-to-back starts.
- `out` updates only on the transition into DONE.

## Configuration
- `BOOTH_EARLY_TERM_EN`, defined:
  - In RUN, if all remaining unconsumed bits of the extended multiplier register plus the overlap bit are identical, every remaining digit is 0.
  - The block then finishes: the accumulator is shifted to its final alignment and the block enters DONE on the next edge.
  - Latency becomes 2..N+1 cycles. The result is identical to the full-latency case.
- Not defined: fixed latency N+1. The detection logic is absent.

## Structure
- Package `booth_r4_pkg` holds:
  - The state enum (IDLE, RUN, DONE).
  - The digit encoding constants (zero/one/two select, negate flag).
  - The function N(WIDTH).
- Sub-module `booth_r4_digit` (combinational): 3-bit window in; select and negate out.
- The top level holds the FSM, counter, accumulator and early-termination logic.

## Test plan
- Unsigned, WIDTH=16, x=255, y=255 → `out`=65025 (0x0000FE01). `done` arrives exactly 10 cycles after start when the macro is off.
- Unsigned x=65535, y=65535 → 0xFFFE0001. Signed x=-32768, y=-32768 → 0x40000000. Signed x=-128, y=128 → 0xFFFFC000.
- Unsigned x=128, y=0 → 0.
  - With `BOOTH_EARLY_TERM_EN` defined: `done` 2 cycles after start.
  - Macro off: `done` 10 cycles after start.
- Reset asserted 4 cycles into RUN for 11×33 → next cycle IDLE, `out`=0, no `done`. A following start with 80×10 → 800.
- `start` pulsed mid-RUN with different operands (x=5, y=5) while computing 25×5 → result is 125 and latency is unchanged.
- `start` held high during DONE for 64×64 then 36×36 → 4096 then 1296. The second `done` arrives N+1 cycles after the first.

Source files
------------

// File: rtl/booth_r4_pkg.sv
// Shared constants for the radix-4 Booth multiplier: FSM state codes,
// Booth digit select/negate encodings and the iteration count helper.
package booth_r4_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_ONE  = 2'd1;
    localparam logic [1:0] SEL_TWO  = 2'd2;

    localparam logic NEG_POS = 1'b0;
    localparam logic NEG_NEG = 1'b1;

    // Digits needed to cover a WIDTH-bit operand extended to WIDTH+2 bits.
    function automatic int unsigned booth_n(input int unsigned width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth recoder: maps {y[2i+1], y[2i], y[2i-1]} to a magnitude
// select (0/1/2) and a negate flag.
module booth_r4_digit
    import booth_r4_pkg::*;
(
    input  logic [2:0] win,
    output logic [1:0] sel,
    output logic       neg
);

    always_comb begin
        sel = SEL_ZERO;
        neg = NEG_POS;
        case (win)
            3'b001, 3'b010: sel = SEL_ONE;
            3'b011:         sel = SEL_TWO;
            3'b100: begin
                sel = SEL_TWO;
                neg = NEG_NEG;
            end
            3'b101, 3'b110: begin
                sel = SEL_ONE;
                neg = NEG_NEG;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/booth_r4_mult.sv
// Iterative radix-4 Booth multiplier with start/done handshake and a
// per-operation signed/unsigned mode. Early termination: BOOTH_EARLY_TERM_EN.
module booth_r4_mult
    import booth_r4_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   out
);

    localparam int unsigned N  = booth_n(WIDTH);
    localparam int unsigned XW = WIDTH + 2;
    localparam int unsigned PW = WIDTH + 3;
    localparam int unsigned AW = 2 * WIDTH + 4;
    localparam int unsigned CW = $clog2(N + 1);

    logic [1:0]         state_q, state_d;
    logic [XW-1:0]      xm_q, xm_d;
    logic [XW:0]        ym_q, ym_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] out_q, out_d;

    logic [1:0]    sel;
    logic          neg;
    logic [PW-1:0] pp_mag, pp;
    logic [AW-1:0] acc_sum, acc_step;
    logic          x_ext, y_ext;

    booth_r4_digit u_digit (
        .win (ym_q[2:0]),
        .sel (sel),
        .neg (neg)
    );

    assign x_ext = signed_mode & x[WIDTH-1];
    assign y_ext = signed_mode & y[WIDTH-1];

    always_comb begin
        pp_mag = '0;
        case (sel)
            SEL_ONE: pp_mag = {xm_q[XW-1], xm_q};
            SEL_TWO: pp_mag = {xm_q, 1'b0};
            default: pp_mag = '0;
        endcase
        pp = (neg == NEG_NEG) ? -pp_mag : pp_mag;
        // Partial product lands at bit XW; after N shifts of 2 it is aligned.
        acc_sum  = acc_q + AW'({pp, {XW{1'b0}}});
        acc_step = $signed(acc_sum) >>> 2;
    end

    always_comb begin
        state_d = state_q;
        xm_d    = xm_q;
        ym_d    = ym_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    xm_d    = {{2{x_ext}}, x};
                    ym_d    = {{2{y_ext}}, y, 1'b0};
                    acc_d   = '0;
                    cnt_d   = CW'(N);
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d = acc_step;
                ym_d  = $signed(ym_q) >>> 2;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    out_d   = acc_step[2*WIDTH-1:0];
                    state_d = ST_DONE;
                end
`ifdef BOOTH_EARLY_TERM_EN
                // Uniform remaining bits mean only zero digits are left, so
                // the outstanding shifts can be applied in one go.
                if ((&ym_q) || !(|ym_q)) begin
                    out_d   = (2*WIDTH)'($signed(acc_q) >>> {cnt_q, 1'b0});
                    state_d = ST_DONE;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            xm_q    <= '0;
            ym_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            xm_q    <= xm_d;
            ym_q    <= ym_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign out  = out_q;

endmodule
